// File: rtl/cordic_rr_sched.sv
// Round-robin front end sharing one CORDIC vectoring core among N_REQ clients.
// One op in flight: accept, pulse the core, wait a fixed latency, return the tagged angle.
module cordic_rr_sched #(
  parameter  int N_REQ      = 4,
  parameter  int DW         = 32,
  parameter  int CORDIC_LAT = 20,
  localparam int IDW        = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*DW-1:0]   req_x,
  input  logic [N_REQ*DW-1:0]   req_y,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [DW-1:0]         rsp_angle,
  output logic                  cor_start,
  output logic [DW-1:0]         cor_x,
  output logic [DW-1:0]         cor_y,
  input  logic [DW-1:0]         cor_angle,
  output logic                  busy
);
  localparam int CW = (CORDIC_LAT > 1) ? $clog2(CORDIC_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                      r_state, w_nxt;
  logic [IDW-1:0]              r_ptr;
  logic [CW-1:0]               r_cnt;
  logic [DW-1:0]               r_cor_x, r_cor_y, r_rsp_angle;
  logic [IDW-1:0]              r_rsp_id;
  logic                        w_gnt_vld;
  logic [IDW-1:0]              w_gnt;
  logic [N_REQ-1:0][DW-1:0]    w_x, w_y;

  assign w_x = req_x;
  assign w_y = req_y;

  // Scan from the far end so the candidate closest to r_ptr is written last and wins.
  always_comb begin
    int j;
    logic [IDW-1:0] jj;
    j         = 0;
    jj        = '0;
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      j  = int'(r_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      jj = IDW'(j);
      if (req_valid[jj]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = jj;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && r_state == S_IDLE && w_gnt_vld) req_ready[w_gnt] = 1'b1;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_gnt_vld) w_nxt = S_ISSUE;
      S_ISSUE: w_nxt = S_WAIT;
      S_WAIT:  if (r_cnt == '0) w_nxt = S_RESP;
      S_RESP:  if (rsp_ready) w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_cor_x     <= '0;
      r_cor_y     <= '0;
      r_rsp_id    <= '0;
      r_rsp_angle <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_gnt_vld) begin
          r_cor_x  <= w_x[w_gnt];
          r_cor_y  <= w_y[w_gnt];
          r_rsp_id <= w_gnt;
        end
        S_ISSUE: r_cnt <= CW'(CORDIC_LAT - 1);
        S_WAIT: begin
          if (r_cnt == '0) r_rsp_angle <= cor_angle;
          else             r_cnt       <= r_cnt - CW'(1);
        end
        S_RESP: if (rsp_ready)
          r_ptr <= (r_rsp_id == IDW'(N_REQ - 1)) ? '0 : r_rsp_id + IDW'(1);
        default: ;
      endcase
    end
  end

  assign cor_start = (r_state == S_ISSUE);
  assign busy      = (r_state != S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_id    = r_rsp_id;
  assign rsp_angle = r_rsp_angle;
  assign cor_x     = r_cor_x;
  assign cor_y     = r_cor_y;

endmodule

// File: tb/tb_cordic_rr_sched.sv
// Bench for cordic_rr_sched: stand-in core (x+y delayed CORDIC_LAT), transaction model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_cordic_rr_sched;
  localparam int NR = 4, DW = 32, LAT = 20, IW = 2;

  logic              clk = 0, rst_n = 0;
  logic [NR-1:0]     req_valid = '0, req_ready;
  logic [NR*DW-1:0]  req_x = '0, req_y = '0;
  logic              rsp_valid, rsp_ready = 0, cor_start, busy;
  logic [IW-1:0]     rsp_id;
  logic [DW-1:0]     rsp_angle, cor_x, cor_y, cor_angle;

  logic [1:0]        req_valid1 = '0, req_ready1;
  logic [31:0]       req_x1 = '0, req_y1 = '0;
  logic              rsp_valid1, rsp_ready1 = 1, cor_start1, busy1;
  logic [0:0]        rsp_id1;
  logic [15:0]       rsp_angle1, cor_x1, cor_y1, cor_angle1, r_core1;

  cordic_rr_sched #(.N_REQ(NR), .DW(DW), .CORDIC_LAT(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_angle(rsp_angle), .cor_start(cor_start), .cor_x(cor_x),
    .cor_y(cor_y), .cor_angle(cor_angle), .busy(busy));

  cordic_rr_sched #(.N_REQ(2), .DW(16), .CORDIC_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_x(req_x1), .req_y(req_y1), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
    .rsp_id(rsp_id1), .rsp_angle(rsp_angle1), .cor_start(cor_start1), .cor_x(cor_x1),
    .cor_y(cor_y1), .cor_angle(cor_angle1), .busy(busy1));

  always #5 clk = ~clk;

  // Stand-in cores: angle = x + y, registered LAT deep.
  logic [DW-1:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= cor_x + cor_y;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign cor_angle = pipe[LAT-1];
  always @(posedge clk) r_core1 <= cor_x1 + cor_y1;
  assign cor_angle1 = r_core1;

  int n_chk = 0, n_err = 0;
  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int winner(input logic [NR-1:0] v, input int p);
    for (int k = 0; k < NR; k++) if (v[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  // Transaction model: one op owned from accept cycle m_tacc until the response handshake.
  int            m_c = 0, m_tacc = 0, m_ptr = 0, m_id = 0;
  bit            m_busy = 0;
  logic [DW-1:0] m_x = '0, m_y = '0;

  always @(negedge clk) begin : cmp
    int            w;
    logic [NR-1:0] e_rr;
    bit            e_cs, e_rv;
    logic [DW-1:0] e_ang;
    if (!rst_n) begin
      m_busy = 0; m_ptr = 0; m_id = 0; m_x = '0; m_y = '0;
    end
    w     = winner(req_valid, m_ptr);
    e_rr  = '0;
    if (rst_n && !m_busy && w >= 0) e_rr = NR'(1) << w;
    e_cs  = m_busy && (m_c == m_tacc + 1);
    e_rv  = m_busy && (m_c >= m_tacc + LAT + 2);
    e_ang = rst_n ? m_x + m_y : '0;
    chk("req_ready", req_ready, e_rr);
    chk("cor_start", cor_start, e_cs);
    chk("busy", busy, m_busy);
    chk("rsp_valid", rsp_valid, e_rv);
    chk("cor_x", $signed(cor_x), $signed(m_x));
    chk("cor_y", $signed(cor_y), $signed(m_y));
    chk("rsp_id", rsp_id, m_id);
    if (e_rv || !rst_n) chk("rsp_angle", $signed(rsp_angle), $signed(e_ang));
    if (rst_n) begin
      if (e_rv && rsp_ready) begin
        m_busy = 0;
        m_ptr  = (m_id + 1) % NR;
      end else if (!m_busy && w >= 0) begin
        m_busy = 1; m_id = w; m_tacc = m_c;
        m_x = req_x[w*DW +: DW];
        m_y = req_y[w*DW +: DW];
      end
    end
    m_c++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int x, input int y);
    req_x[i*DW +: DW] = DW'(x);
    req_y[i*DW +: DW] = DW'(y);
    req_valid[i]      = 1'b1;
  endtask

  // which: 0 cor_start, 1 rsp_valid, other = some request accepted
  task automatic wait_out(input int which, output int n);
    bit hit;
    n = 0; hit = 0;
    while (!hit && n < 200) begin
      @(negedge clk);
      n++;
      case (which)
        0:       hit = cor_start;
        1:       hit = rsp_valid;
        default: hit = |(req_ready & req_valid);
      endcase
    end
    if (!hit) chk("wait_timeout_event", which, -1);
  endtask

  task automatic accept_one(output int idx, output int n, output int t);
    wait_out(2, n);
    idx = -1;
    for (int k = 0; k < NR; k++) if (req_ready[k] && req_valid[k]) idx = k;
    t = int'($time / 10);
    @(posedge clk); #1;
    if (idx >= 0) req_valid[idx] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int idx, n, t, t0, bad;
    int exp2 [4] = '{0, 11, 22, 33};
    t0 = 0;
    tick(3); rst_n = 1;

    // 1: lone request from client 2
    rsp_ready = 1;
    set_req(2, -6, -8);
    accept_one(idx, n, t);   chk("t1_grant", idx, 2);
    wait_out(0, n);          chk("t1_start_after_accept", n, 1);
    wait_out(1, n);          chk("t1_rsp_after_start", n, LAT + 1);
    chk("t1_id", rsp_id, 2);
    chk("t1_angle", $signed(rsp_angle), -14);
    tick(1);

    // 2: all four valid out of reset
    rst_n = 0; tick(2); rst_n = 1;
    for (int i = 0; i < NR; i++) set_req(i, i, 10 * i);
    for (int k = 0; k < NR; k++) begin
      accept_one(idx, n, t);
      chk("t2_grant_order", idx, k);
      if (k > 0) chk("t2_issue_spacing", t - t0, LAT + 3);
      t0 = t;
      wait_out(1, n);
      chk("t2_angle", $signed(rsp_angle), exp2[k]);
    end
    tick(1);

    // 3: serve 1, then 0 and 1 together; pointer at 2 wraps to 0 first
    set_req(1, 2, 3);
    accept_one(idx, n, t);   chk("t3_first", idx, 1);
    wait_out(1, n);          tick(1);
    set_req(0, 4, 4); set_req(1, 5, 5);
    accept_one(idx, n, t);   chk("t3_wrap_grant", idx, 0);
    wait_out(1, n);          tick(1);
    accept_one(idx, n, t);   chk("t3_second", idx, 1);
    wait_out(1, n);          chk("t3_angle", $signed(rsp_angle), 10);
    tick(1);

    // 4: backpressure with client 3 pending
    rsp_ready = 0;
    set_req(2, 5, 7);
    accept_one(idx, n, t);   chk("t4_grant", idx, 2);
    set_req(3, -1, -1);
    wait_out(1, n);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (!(rsp_valid && rsp_id == 2 && $signed(rsp_angle) == 12 && req_ready == '0 &&
            !cor_start && cor_x == 5 && cor_y == 7)) bad++;
    end
    chk("t4_hold_bad_cycles", bad, 0);
    tick(1); rsp_ready = 1;
    accept_one(idx, n, t);
    chk("t4_accept_delay", n, 2);
    chk("t4_grant_pending", idx, 3);
    wait_out(1, n);          chk("t4_angle", $signed(rsp_angle), -2);
    tick(1);

    // 5: reset in the middle of the wait
    set_req(0, 3, 4);
    accept_one(idx, n, t);   chk("t5_pre_grant", idx, 0);
    wait_out(1, n);          chk("t5_pre_angle", $signed(rsp_angle), 7);
    tick(1);
    set_req(2, 9, 9);
    accept_one(idx, n, t);   chk("t5_grant", idx, 2);
    wait_out(0, n);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 0; req_valid = '0;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_cor_x", cor_x, 0);
    chk("t5_rst_rsp_id", rsp_id, 0);
    chk("t5_rst_req_ready", req_ready, 0);
    tick(2); rst_n = 1;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid || busy) bad++;
    end
    chk("t5_no_stale_rsp", bad, 0);
    tick(1);
    set_req(0, 1, 1); set_req(1, 2, 2);
    accept_one(idx, n, t);   chk("t5_ptr_reset_grant", idx, 0);
    wait_out(1, n);          chk("t5_angle", $signed(rsp_angle), 2);
    tick(1);
    accept_one(idx, n, t);   chk("t5_next_grant", idx, 1);
    wait_out(1, n);          tick(1);

    // 6: single-cycle core latency build
    req_x1[16 +: 16] = 16'd100;
    req_y1[16 +: 16] = 16'hFFFD;
    req_valid1 = 2'b10;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready1[1] && n < 50);
    chk("t6_grant", req_ready1, 2);
    @(posedge clk); #1; req_valid1 = '0;
    n = 0;
    do begin @(negedge clk); n++; end while (!cor_start1 && n < 50);
    chk("t6_start_after_accept", n, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid1 && n < 50);
    chk("t6_rsp_after_start", n, 2);
    chk("t6_angle", $signed(rsp_angle1), 97);
    chk("t6_id", rsp_id1, 1);
    tick(2);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
